// File: rtl/obi_rr_mux.sv
// rtl/obi_rr_mux.sv - round-robin N:1 OBI multiplexer with in-order response routing
// Grant is zero-latency; issued port indices are queued so responses route back in order.
module obi_rr_mux #(
    parameter int unsigned NumSbrPorts = 4,
    parameter int unsigned MaxTrans    = 4,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    localparam int unsigned BeWidth    = DataWidth / 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumSbrPorts-1:0]                sbr_req_i,
    output logic [NumSbrPorts-1:0]                sbr_gnt_o,
    input  logic [NumSbrPorts-1:0][AddrWidth-1:0] sbr_addr_i,
    input  logic [NumSbrPorts-1:0]                sbr_we_i,
    input  logic [NumSbrPorts-1:0][BeWidth-1:0]   sbr_be_i,
    input  logic [NumSbrPorts-1:0][DataWidth-1:0] sbr_wdata_i,
    output logic [NumSbrPorts-1:0]                sbr_rvalid_o,
    output logic [DataWidth-1:0]                  sbr_rdata_o,
    output logic                                  sbr_err_o,
    output logic                                  mgr_req_o,
    input  logic                                  mgr_gnt_i,
    output logic [AddrWidth-1:0]                  mgr_addr_o,
    output logic                                  mgr_we_o,
    output logic [BeWidth-1:0]                    mgr_be_o,
    output logic [DataWidth-1:0]                  mgr_wdata_o,
    input  logic                                  mgr_rvalid_i,
    input  logic [DataWidth-1:0]                  mgr_rdata_i,
    input  logic                                  mgr_err_i,
    output logic                                  fault_o
);
    localparam int unsigned IdxW = $clog2(NumSbrPorts);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSbrPorts - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxTrans);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            fault_q, fault_d;
    logic [IdxW-1:0] id_fifo_q [MaxTrans];

    // While reset is high the outputs must already look like the cleared state.
    logic [IdxW-1:0] rr_ptr_eff;
    logic            lock_eff;
    logic [CntW-1:0] cnt_eff;
    assign rr_ptr_eff = rst_i ? '0 : rr_ptr_q;
    assign lock_eff   = ~rst_i & lock_q;
    assign cnt_eff    = rst_i ? '0 : cnt_q;

    logic [IdxW-1:0] arb_idx;
    logic            arb_found;
    logic [IdxW-1:0] sel_idx;
    logic            empty, full, hs, pop;
    int unsigned     cand;

    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NumSbrPorts; off++) begin
            cand = (32'(rr_ptr_eff) + off) % NumSbrPorts;
            if (!arb_found && sbr_req_i[IdxW'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IdxW'(cand);
            end
        end
    end

    assign sel_idx   = lock_eff ? lock_idx_q : arb_idx;
    assign empty     = (cnt_eff == '0);
    assign full      = (cnt_eff == FullCnt);
    assign mgr_req_o = (lock_eff | arb_found) & ~full;
    assign hs        = mgr_req_o & mgr_gnt_i;
    assign pop       = mgr_rvalid_i & ~empty;

    assign mgr_addr_o  = sbr_addr_i[sel_idx];
    assign mgr_we_o    = sbr_we_i[sel_idx];
    assign mgr_be_o    = sbr_be_i[sel_idx];
    assign mgr_wdata_o = sbr_wdata_i[sel_idx];
    assign sbr_rdata_o = mgr_rdata_i;
    assign sbr_err_o   = mgr_err_i;
    assign fault_o     = fault_q;

    always_comb begin
        sbr_gnt_o    = '0;
        sbr_rvalid_o = '0;
        if (hs) begin
            sbr_gnt_o[sel_idx] = 1'b1;
        end
        if (pop) begin
            sbr_rvalid_o[id_fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q + CntW'(hs) - CntW'(pop);
        fault_d    = fault_q | (mgr_rvalid_i & empty);
        if (hs) begin
            rr_ptr_d = (sel_idx == LastIdx) ? '0 : sel_idx + 1'b1;
            lock_d   = 1'b0;
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end else if (mgr_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fault_q    <= fault_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && hs) begin
            id_fifo_q[wr_ptr_q] <= sel_idx;
        end
    end
endmodule

// File: tb/tb_obi_rr_mux.sv
// tb/tb_obi_rr_mux.sv - directed-vector bench for obi_rr_mux
module tb_obi_rr_mux;
    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        sbr_req;
    logic [3:0]        sbr_gnt;
    logic [3:0][31:0]  sbr_addr;
    logic [3:0]        sbr_we;
    logic [3:0][3:0]   sbr_be;
    logic [3:0][31:0]  sbr_wdata;
    logic [3:0]        sbr_rvalid;
    logic [31:0]       sbr_rdata;
    logic              sbr_err;
    logic              mgr_req;
    logic              mgr_gnt;
    logic [31:0]       mgr_addr;
    logic              mgr_we;
    logic [3:0]        mgr_be;
    logic [31:0]       mgr_wdata;
    logic              mgr_rvalid;
    logic [31:0]       mgr_rdata;
    logic              mgr_err;
    logic              fault;

    int n_vec = 0;
    int n_err = 0;

    obi_rr_mux #(.NumSbrPorts(4), .MaxTrans(4), .AddrWidth(32), .DataWidth(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .sbr_req_i(sbr_req), .sbr_gnt_o(sbr_gnt), .sbr_addr_i(sbr_addr),
        .sbr_we_i(sbr_we), .sbr_be_i(sbr_be), .sbr_wdata_i(sbr_wdata),
        .sbr_rvalid_o(sbr_rvalid), .sbr_rdata_o(sbr_rdata), .sbr_err_o(sbr_err),
        .mgr_req_o(mgr_req), .mgr_gnt_i(mgr_gnt), .mgr_addr_o(mgr_addr),
        .mgr_we_o(mgr_we), .mgr_be_o(mgr_be), .mgr_wdata_o(mgr_wdata),
        .mgr_rvalid_i(mgr_rvalid), .mgr_rdata_i(mgr_rdata), .mgr_err_i(mgr_err),
        .fault_o(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [3:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic er);
        sbr_req    = req;
        mgr_gnt    = gnt;
        mgr_rvalid = rv;
        mgr_rdata  = rd;
        mgr_err    = er;
        #2;
    endtask

    function automatic logic [31:0] addr_of(input int p);
        return 32'h1000 + 32'(p) * 32'h100;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            sbr_addr[i]  = addr_of(i);
            sbr_we[i]    = i[0];
            sbr_be[i]    = 4'hF;
            sbr_wdata[i] = 32'hD0 + 32'(i);
        end

        // reset: outputs derived from cleared state
        rst = 1'b1;
        set(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_mgr_req", mgr_req, 0);
        chk("rst_gnt", sbr_gnt, 0);
        chk("rst_rvalid", sbr_rvalid, 0);
        tick();
        chk("rst_fault", fault, 0);
        set(4'b0100, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_req_live", mgr_req, 1);
        chk("rst_addr", mgr_addr, addr_of(2));
        tick();
        rst = 1'b0;
        set(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("idle_req", mgr_req, 0);

        // all four request, grant always: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            set(4'hF, 1'b1, k > 0, 32'h100 + 32'(k), 1'b0);
            chk("rr_gnt", sbr_gnt, 32'(1) << (k % 4));
            chk("rr_addr", mgr_addr, addr_of(k % 4));
            chk("rr_rvalid", sbr_rvalid, (k > 0) ? (32'(1) << ((k - 1) % 4)) : 32'h0);
            chk("rr_rdata", sbr_rdata, 32'h100 + 32'(k));
            tick();
        end
        set(4'b0000, 1'b0, 1'b1, 32'h200, 1'b0);
        chk("rr_last_rvalid", sbr_rvalid, 32'b0001);
        tick();

        rst = 1'b1;
        set(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;

        // lock: port 2 held across three stalled cycles despite port 0
        set(4'b0100, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("lock_req", mgr_req, 1);
        chk("lock_addr0", mgr_addr, addr_of(2));
        chk("lock_gnt0", sbr_gnt, 0);
        tick();
        for (int k = 1; k < 3; k++) begin
            set(4'b0101, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("lock_addr", mgr_addr, addr_of(2));
            chk("lock_gnt", sbr_gnt, 0);
            tick();
        end
        set(4'b0101, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("lock_gnt2", sbr_gnt, 32'b0100);
        chk("lock_addr3", mgr_addr, addr_of(2));
        tick();
        set(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("lock_gnt_next", sbr_gnt, 32'b0001);
        chk("lock_addr_next", mgr_addr, addr_of(0));
        tick();
        set(4'b0000, 1'b0, 1'b1, 32'h22, 1'b0);
        chk("lock_rsp0", sbr_rvalid, 32'b0100);
        tick();
        set(4'b0000, 1'b0, 1'b1, 32'h23, 1'b0);
        chk("lock_rsp1", sbr_rvalid, 32'b0001);
        tick();

        // fill to MaxTrans with pointer at 1: grants 1,2,3,0
        for (int k = 0; k < 4; k++) begin
            set(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
            chk("fill_gnt", sbr_gnt, 32'(1) << ((1 + k) % 4));
            tick();
        end
        set(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("full_req", mgr_req, 0);
        chk("full_gnt", sbr_gnt, 0);
        tick();
        set(4'hF, 1'b1, 1'b1, 32'h33, 1'b0);
        chk("full_pop_req", mgr_req, 0);
        chk("full_pop_gnt", sbr_gnt, 0);
        chk("full_pop_rvalid", sbr_rvalid, 32'b0010);
        tick();
        set(4'hF, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("resume_req", mgr_req, 1);
        chk("resume_gnt", sbr_gnt, 32'b0010);
        tick();
        for (int k = 0; k < 4; k++) begin
            set(4'b0000, 1'b0, 1'b1, 32'h40 + 32'(k), 1'b0);
            chk("drain_rvalid", sbr_rvalid, 32'(1) << ((2 + k) % 4));
            tick();
        end

        // in-order return: issue 3,1,1 then three responses
        set(4'b1000, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ord_gnt3", sbr_gnt, 32'b1000);
        tick();
        set(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ord_gnt1a", sbr_gnt, 32'b0010);
        tick();
        set(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("ord_gnt1b", sbr_gnt, 32'b0010);
        tick();
        set(4'b0000, 1'b0, 1'b1, 32'hA, 1'b0);
        chk("ord_rv_a", sbr_rvalid, 32'b1000);
        chk("ord_rd_a", sbr_rdata, 32'hA);
        tick();
        set(4'b0000, 1'b0, 1'b1, 32'hB, 1'b1);
        chk("ord_rv_b", sbr_rvalid, 32'b0010);
        chk("ord_rd_b", sbr_rdata, 32'hB);
        chk("ord_err_b", sbr_err, 1);
        tick();
        set(4'b0000, 1'b0, 1'b1, 32'hC, 1'b0);
        chk("ord_rv_c", sbr_rvalid, 32'b0010);
        chk("ord_rd_c", sbr_rdata, 32'hC);
        tick();

        // spurious response after reset sets sticky fault
        rst = 1'b1;
        set(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        set(4'b0000, 1'b0, 1'b1, 32'h55, 1'b0);
        chk("spur_rvalid", sbr_rvalid, 0);
        chk("spur_fault_pre", fault, 0);
        tick();
        set(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("spur_fault", fault, 1);
        tick();
        chk("spur_fault_held", fault, 1);
        set(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("fault_traffic_gnt", sbr_gnt, 32'b0001);
        tick();
        set(4'b0000, 1'b0, 1'b1, 32'h66, 1'b0);
        chk("fault_traffic_rv", sbr_rvalid, 32'b0001);
        chk("fault_still", fault, 1);
        tick();

        // reset with two outstanding drops them; pointer is at 1 here
        set(4'b0011, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst2_gnt_a", sbr_gnt, 32'b0010);
        tick();
        set(4'b0011, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst2_gnt_b", sbr_gnt, 32'b0001);
        tick();
        rst = 1'b1;
        set(4'b0000, 1'b0, 1'b1, 32'h77, 1'b0);
        chk("rst2_no_rvalid", sbr_rvalid, 0);
        tick();
        rst = 1'b0;
        set(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst2_fault_clr", fault, 0);
        chk("rst2_idle_req", mgr_req, 0);
        set(4'b0100, 1'b1, 1'b1, 32'h88, 1'b0);
        chk("rst2_hs_gnt", sbr_gnt, 32'b0100);
        chk("rst2_hs_rvalid", sbr_rvalid, 0);
        tick();
        set(4'b0000, 1'b0, 1'b1, 32'h99, 1'b0);
        chk("rst2_fault_set", fault, 1);
        chk("rst2_rvalid_p2", sbr_rvalid, 32'b0100);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/obi_rr_mux.md
OBI_RR_MUX -- requirements
Module: obi_rr_mux

Interface
REQ-001 SHALL have parameter NumSbrPorts, default 4, number of requesting subordinate ports (2..16).
REQ-002 SHALL have parameter MaxTrans, default 4, max outstanding transactions on the manager port (1..16).
REQ-003 SHALL have parameter AddrWidth, default 32, address width.
REQ-004 SHALL have parameter DataWidth, default 32, data width; byte enable width BeWidth = DataWidth/8.
REQ-005 Ports SHALL be, in order:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
sbr_req_i  in  NumSbrPorts  per-port request
sbr_gnt_o  out  NumSbrPorts  per-port grant
sbr_addr_i  in  NumSbrPorts x AddrWidth  per-port address
sbr_we_i  in  NumSbrPorts  per-port write enable
sbr_be_i  in  NumSbrPorts x BeWidth  per-port byte enable
sbr_wdata_i  in  NumSbrPorts x DataWidth  per-port write data
sbr_rvalid_o  out  NumSbrPorts  per-port response valid
sbr_rdata_o  out  DataWidth  response data, broadcast to all ports
sbr_err_o  out  1  response error, broadcast
mgr_req_o  out  1  manager request
mgr_gnt_i  in  1  manager grant
mgr_addr_o / mgr_we_o / mgr_be_o / mgr_wdata_o  out  AddrWidth / 1 / BeWidth / DataWidth  selected A-channel
mgr_rvalid_i  in  1  manager response valid
mgr_rdata_i  in  DataWidth  response data
mgr_err_i  in  1  response error
fault_o  out  1  sticky protocol-fault flag
REQ-006 Clock SHALL be clk_i only; reset SHALL be rst_i, synchronous, active-high.

Function
REQ-007 Arbitration SHALL be round-robin: priority starts at index rr_ptr, ascending with wrap; lowest-index wins ties after rotation.
REQ-008 rr_ptr SHALL update only on an A handshake (mgr_req_o & mgr_gnt_i): rr_ptr <= winner+1, wrapping NumSbrPorts-1 -> 0.
REQ-009 Lock: when mgr_req_o=1 and mgr_gnt_i=0, the selected index SHALL be registered and held until handshake; new requests on other ports SHALL NOT change selection.
REQ-010 mgr_req_o SHALL be 1 iff any sbr_req_i (or locked port) is asserted and outstanding count < MaxTrans; A-channel outputs SHALL mirror the selected port combinationally.
REQ-011 sbr_gnt_o[i] SHALL equal mgr_gnt_i & mgr_req_o & (selected==i); all other bits 0; zero-latency grant path.
REQ-012 Each handshake SHALL push the winner index into an ID FIFO of depth MaxTrans; outstanding counter width clog2(MaxTrans+1).
REQ-013 Full (count==MaxTrans): mgr_req_o=0 and sbr_gnt_o=0, even if mgr_rvalid_i pops that cycle; issue resumes next cycle.
REQ-014 mgr_rvalid_i with count>0 SHALL assert sbr_rvalid_o[FIFO head] in the same cycle and pop the FIFO; rdata/err passed through combinationally.
REQ-015 Simultaneous push and pop (count not full) SHALL leave count unchanged and preserve FIFO order.
REQ-016 mgr_rvalid_i with count==0 (including same cycle as the first handshake) SHALL drive no sbr_rvalid_o, not pop, and set fault_o on the next edge.
REQ-017 fault_o SHALL stay 1 until reset; it SHALL NOT block further traffic.
REQ-018 Responses SHALL be returned strictly in issue order; no rready backpressure (responses always accepted).

Reset
REQ-019 On rst_i=1 at a rising edge: rr_ptr=0, lock cleared, FIFO empty, count=0, fault_o=0.
REQ-020 During reset cycle outputs SHALL be combinational from cleared state: mgr_req_o follows REQ-010 with count=0; reset mid-transaction SHALL drop outstanding IDs without generating sbr_rvalid_o.

Verification
REQ-021 All 4 ports request, mgr_gnt_i=1 always -> grants in order 0,1,2,3,0; rr_ptr wraps to 0.
REQ-022 Port 2 requests, mgr_gnt_i=0 for 3 cycles, port 0 requests at cycle 1 -> mgr_addr_o stays port 2's address; port 2 granted cycle 3, port 0 granted next.
REQ-023 MaxTrans=4, 4 grants, no rvalid -> 5th cycle mgr_req_o=0; one rvalid -> issue resumes next cycle.
REQ-024 Issue ports 3,1,1 then three rvalids with rdata 0xA,0xB,0xC -> sbr_rvalid_o pulses on ports 3,1,1 with matching data.
REQ-025 mgr_rvalid_i=1 after reset with no issue -> no sbr_rvalid_o, fault_o=1 next cycle, remains 1 until rst_i.
REQ-026 rst_i asserted with 2 outstanding -> count=0, fault_o=0; later rvalid sets fault_o.
